add3_share_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 3-operand adder (WIDTH-bit, sum mod 2^WIDTH, no carry out) among NREQ requesters.
- Each requester offers three operands with a valid/ready handshake.
- The scheduler grants one requester per cycle and drives the adder inputs. It registers the adder result into a single-entry response buffer tagged with the requester id.
- Sits between requester blocks and the shared adder instance; the adder lives outside this block.

---
 rtl/add3_share_sched_if.sv | 59 +++++
 rtl/add3_share_sched.sv | 140 ++++++++++++++
 tb/tb_add3_share_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add3_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : add3_share_sched_if
//  Description : Bundle connecting NREQ operand requesters, the shared
//                3-operand adder and the response consumer to the
//                add3_share_sched scheduler.
//                Requester side : req_valid / req_ready / req_a / req_b / req_c
//                Adder side     : add_in1..3 (to adder), add_out1 (from adder)
//                Response side  : rsp_valid / rsp_ready / rsp_sum / rsp_id
//                Statistics     : stat_sel / stat_cnt, present only when
//                                 ADD3_SHARE_SCHED_STATS_EN is defined
//  Modports    : slave  - the scheduler
//                master - the surrounding requesters, adder and consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface add3_share_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic [WIDTH-1:0]      add_in1;
  logic [WIDTH-1:0]      add_in2;
  logic [WIDTH-1:0]      add_in3;
  logic [WIDTH-1:0]      add_out1;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic [IDW-1:0]        rsp_id;
`ifdef ADD3_SHARE_SCHED_STATS_EN
  logic [IDW-1:0]        stat_sel;
  logic [7:0]            stat_cnt;
`endif

  modport slave (
    input  req_valid, req_a, req_b, req_c, add_out1, rsp_ready,
`ifdef ADD3_SHARE_SCHED_STATS_EN
    input  stat_sel,
    output stat_cnt,
`endif
    output req_ready, add_in1, add_in2, add_in3, rsp_valid, rsp_sum, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_c, add_out1, rsp_ready,
`ifdef ADD3_SHARE_SCHED_STATS_EN
    output stat_sel,
    input  stat_cnt,
`endif
    input  req_ready, add_in1, add_in2, add_in3, rsp_valid, rsp_sum, rsp_id
  );

endinterface
`default_nettype wire

// File: rtl/add3_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : add3_share_sched
//  Description : Round-robin scheduler sharing one external combinational
//                3-operand adder among NREQ requesters. One requester is
//                granted per cycle; the adder result is captured into a
//                single-entry response buffer tagged with the requester id.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - synchronous active-high reset
//                bus  - add3_share_sched_if.slave (requests, adder, response)
//  Parameters  : NREQ (2..8) requesters, WIDTH operand/sum width.
//  Options     : ADD3_SHARE_SCHED_STATS_EN adds per-requester saturating
//                8-bit grant counters readable through stat_sel/stat_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module add3_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  add3_share_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic             w_hi_found, w_lo_found;
  logic [IDW-1:0]   w_hi_idx, w_lo_idx, w_gnt_idx;
  logic             w_can_accept, w_accept;

  // Round-robin search done as two priority scans: the lowest valid index at
  // or above the pointer wins; if none, wrap to the lowest valid index overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDW'(i);
        if (i >= int'(ptr_q)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDW'(i);
        end
      end
    end
  end

  assign w_gnt_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_can_accept = (state_q == S_EMPTY) | bus.rsp_ready;
  assign w_accept     = w_lo_found & w_can_accept & ~rst;

  // Adder inputs are forced to zero whenever nothing is granted so the shared
  // adder does not toggle on idle cycles.
  always_comb begin
    bus.req_ready = '0;
    bus.add_in1   = '0;
    bus.add_in2   = '0;
    bus.add_in3   = '0;
    if (w_accept) begin
      bus.req_ready[w_gnt_idx] = 1'b1;
      bus.add_in1 = bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
      bus.add_in2 = bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
      bus.add_in3 = bus.req_c[int'(w_gnt_idx)*WIDTH +: WIDTH];
    end
  end

  // An accept while FULL with rsp_ready high overwrites the buffer in place,
  // which keeps throughput at one operation per cycle.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (w_accept) begin
      state_d = S_FULL;
      sum_d   = bus.add_out1;
      id_d    = w_gnt_idx;
      ptr_d   = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
    end else if ((state_q == S_FULL) && bus.rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.rsp_valid = (state_q == S_FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;

`ifdef ADD3_SHARE_SCHED_STATS_EN
  logic [7:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept && (w_gnt_idx == IDW'(i)) && (cnt_q[i] != 8'hFF)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Compare-based read mux: selectors past NREQ-1 fall through to zero.
  always_comb begin
    bus.stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(bus.stat_sel) == i) begin
        bus.stat_cnt = cnt_q[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_add3_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add3_share_sched
//  Description : Self-checking bench for add3_share_sched. A behavioural model
//                (pointer, buffer contents, grant counters) predicts grant,
//                adder inputs and response each cycle; directed scenarios add
//                fixed-value checks. Stats checks compile in when
//                ADD3_SHARE_SCHED_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add3_share_sched;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // model state
  int m_ptr;
  bit m_full;
  int m_sum;
  int m_id;
  int m_cnt [NREQ];

  add3_share_sched_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  // external shared adder
  assign bus.add_out1 = W'(bus.add_in1 + bus.add_in2 + bus.add_in3);

  add3_share_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_full = 0;
    m_sum  = 0;
    m_id   = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
    bus.req_c[i*W +: W] = W'(c);
  endtask

  task automatic rand_ops();
    bus.req_a = 16'($urandom);
    bus.req_b = 16'($urandom);
    bus.req_c = 16'($urandom);
  endtask

  // One clock: check DUT against model at the falling edge, then advance the
  // model across the rising edge using the same inputs.
  task automatic cycle();
    int g;
    int idx;
    int ea, eb, ec;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g = -1;
    if (!rst && (!m_full || bus.rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    er = '0; ea = 0; eb = 0; ec = 0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ea = int'(bus.req_a[g*W +: W]);
      eb = int'(bus.req_b[g*W +: W]);
      ec = int'(bus.req_c[g*W +: W]);
    end
    chk("req_ready", bus.req_ready, er);
    chk("add_in1", bus.add_in1, ea);
    chk("add_in2", bus.add_in2, eb);
    chk("add_in3", bus.add_in3, ec);
    chk("rsp_valid", bus.rsp_valid, m_full);
    chk("rsp_sum", bus.rsp_sum, m_sum);
    chk("rsp_id", bus.rsp_id, m_id);
`ifdef ADD3_SHARE_SCHED_STATS_EN
    chk("stat_cnt", bus.stat_cnt, (int'(bus.stat_sel) < NREQ) ? m_cnt[bus.stat_sel] : 0);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_full = 1;
      m_sum  = (ea + eb + ec) % (1 << W);
      m_id   = g;
      m_ptr  = (g + 1) % NREQ;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end else if (m_full && bus.rsp_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.rsp_ready = 1'b0;
`ifdef ADD3_SHARE_SCHED_STATS_EN
    bus.stat_sel = '0;
`endif
    @(posedge clk);
    #1;
    model_reset();

    // reset held three cycles with every requester valid
    bus.req_valid = 4'hF;
    rand_ops();
    repeat (3) cycle();
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_sum", bus.rsp_sum, 0);

    // first grant after release goes to requester 0
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("first_grant", bus.req_ready, 4'b0001);
    cycle();

    // single op from requester 1
    bus.req_valid = 4'b0010;
    set_op(1, 3, 4, 5);
    #1;
    chk("single_ready", bus.req_ready, 4'b0010);
    chk("single_in1", bus.add_in1, 3);
    chk("single_in2", bus.add_in2, 4);
    chk("single_in3", bus.add_in3, 5);
    cycle();
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_sum", bus.rsp_sum, 12);
    chk("single_id", bus.rsp_id, 1);

    // overflow wrap from requester 3, then search restarts at 0
    bus.req_valid = 4'b1000;
    set_op(3, 15, 15, 15);
    cycle();
    chk("wrap_sum", bus.rsp_sum, 13);
    chk("wrap_id", bus.rsp_id, 3);
    bus.req_valid = 4'hF;
    #1;
    chk("wrap_next_grant", bus.req_ready, 4'b0001);
    cycle();

    // round robin with all requesters valid
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = 4'hF;
    rand_ops();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_id", bus.rsp_id, i % NREQ);
      chk("rr_valid", bus.rsp_valid, 1);
    end

    // backpressure
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = 4'b0100;
    set_op(2, 1, 2, 4);
    bus.rsp_ready = 1'b1;
    cycle();
    chk("bp_fill_sum", bus.rsp_sum, 7);
    chk("bp_fill_id", bus.rsp_id, 2);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready_low", bus.req_ready, 0);
      cycle();
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_sum", bus.rsp_sum, 7);
      chk("bp_hold_id", bus.rsp_id, 2);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 4'b0001);
    cycle();
    chk("bp_release_valid", bus.rsp_valid, 1);
    chk("bp_release_id", bus.rsp_id, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      bus.req_valid = 4'($urandom);
      rand_ops();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 29) == 0);
`ifdef ADD3_SHARE_SCHED_STATS_EN
      bus.stat_sel = 2'($urandom);
`endif
      cycle();
    end
    rst = 1'b0;

`ifdef ADD3_SHARE_SCHED_STATS_EN
    // saturating grant counters
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    bus.stat_sel  = 2'd2;
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      cycle();
    end
    bus.req_valid = '0;
    #1;
    chk("stat_sat", bus.stat_cnt, 255);
    bus.stat_sel = 2'd0;
    #1;
    chk("stat_other", bus.stat_cnt, 0);
    bus.stat_sel = 2'd2;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("stat_after_rst", bus.stat_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
